// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte-to-word packer receive path.
//   BYTE_W   : width of one incoming byte lane
//   state_t  : packer state (COLLECT accepting bytes, PENDING waiting on hold)
//   lane_idx : maps arrival order k to the word lane it occupies
package byte_word_packer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_t;

  // le=1: first byte in lane 0 (word[7:0]); le=0: first byte in the top lane.
  function automatic int lane_idx(input int k, input int bytes, input bit le);
    return le ? k : (bytes - 1 - k);
  endfunction

endpackage

// File: rtl/packer_timeout.sv
// Idle counter for partial-word receive paths.
//   clk, rst : clock, async active-high reset
//   clr      : force the count to zero (takes priority over en and fire)
//   en       : count one idle cycle
//   fire     : combinational; high on the cycle whose edge would reach LIMIT
// LIMIT=0 disables the counter entirely (fire never asserts, count held at 0).
module packer_timeout #(
  parameter int LIMIT = 0,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire
);

  logic [W-1:0] cnt;

  // The edge that takes the count to LIMIT is the firing edge, so compare
  // against LIMIT-1; the count is recycled on that same edge.
  assign fire = (LIMIT != 0) && en && !clr && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              cnt <= '0;
    else if (clr || fire || (LIMIT == 0)) cnt <= '0;
    else if (en)                          cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs BYTES bytes from a valid/ready byte stream into one word and presents
// it with a one-cycle load strobe for an external enabled holding register.
//   clk, rst : clock, async active-high reset
//   byte_in, byte_vld, byte_rdy : byte stream handshake (byte_rdy comb.)
//   hold     : downstream busy; defers word_en while high
//   word_out : assembled word, registered, loaded only on completion
//   word_en  : one-cycle load strobe
//   to_err   : one-cycle pulse when a stale partial word is discarded
//   byte_cnt : bytes currently held in the partial word
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter  int BYTES         = 4,
  parameter  bit LITTLE_ENDIAN = 1'b1,
  parameter  int TIMEOUT_CYC   = 0,
  parameter  int TO_W          = 16,
  localparam int CW            = $clog2(BYTES + 1),
  localparam int WW            = BYTE_W * BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_vld,
  output logic              byte_rdy,
  input  logic              hold,
  output logic [WW-1:0]     word_out,
  output logic              word_en,
  output logic              to_err,
  output logic [CW-1:0]     byte_cnt
);

  state_t                         state;
  logic [BYTES-1:0][BYTE_W-1:0]   shadow, shadow_nxt;
  logic                           xfer, last, to_en, to_clr, to_fire;

  assign byte_rdy = (state == COLLECT);
  assign xfer     = byte_vld && byte_rdy;
  assign last     = (byte_cnt == CW'(BYTES - 1));

  // Idle counting only while a partial word is held and nothing arrives.
  assign to_en  = (state == COLLECT) && (byte_cnt != '0) && !xfer;
  assign to_clr = (state != COLLECT) || (byte_cnt == '0) || xfer;

  packer_timeout #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TO_W)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (to_clr),
    .en   (to_en),
    .fire (to_fire)
  );

  // Shadow with the incoming byte merged in; on the last byte this is the
  // complete word, so word_out is loaded in one shot and never seen partial.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < BYTES; i++)
      if (lane_idx(int'(byte_cnt), BYTES, LITTLE_ENDIAN) == i) shadow_nxt[i] = byte_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      byte_cnt <= '0;
      shadow   <= '0;
      word_out <= '0;
      word_en  <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      word_en <= 1'b0;
      to_err  <= 1'b0;
      case (state)
        COLLECT: begin
          if (xfer) begin
            if (last) begin
              byte_cnt <= '0;
              shadow   <= '0;
              word_out <= shadow_nxt;
              if (hold) state   <= PENDING;
              else      word_en <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              shadow   <= shadow_nxt;
            end
          end else if (to_fire) begin
            byte_cnt <= '0;
            shadow   <= '0;
            to_err   <= 1'b1;
          end
        end
        PENDING: begin
          if (!hold) begin
            word_en <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: three instances share the stimulus
// (little-endian, big-endian, little-endian with a 10-cycle timeout).
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_vld = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  byte_in = 8'h00;

  logic        rdy_le, en_le, te_le;
  logic [31:0] wo_le;
  logic [2:0]  cnt_le;
  logic        rdy_be, en_be, te_be;
  logic [31:0] wo_be;
  logic [2:0]  cnt_be;
  logic        rdy_to, en_to, te_to;
  logic [31:0] wo_to;
  logic [2:0]  cnt_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_word_packer #(.BYTES(4), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYC(0), .TO_W(16)) dut_le (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(rdy_le),
    .hold(hold), .word_out(wo_le), .word_en(en_le), .to_err(te_le), .byte_cnt(cnt_le));

  byte_word_packer #(.BYTES(4), .LITTLE_ENDIAN(1'b0), .TIMEOUT_CYC(0), .TO_W(16)) dut_be (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(rdy_be),
    .hold(hold), .word_out(wo_be), .word_en(en_be), .to_err(te_be), .byte_cnt(cnt_be));

  byte_word_packer #(.BYTES(4), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYC(10), .TO_W(16)) dut_to (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(rdy_to),
    .hold(hold), .word_out(wo_to), .word_en(en_to), .to_err(te_to), .byte_cnt(cnt_to));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; byte_vld = 1'b0; hold = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_vld = 1'b1; byte_in = b;
    tick();
    byte_vld = 1'b0;
  endtask

  initial begin
    int first_en, second_en, pulses, seen;

    // ---- reset state ----
    #1;
    chk("rst_word_out", wo_le, 32'h0);
    chk("rst_word_en", 32'(en_le), 32'h0);
    chk("rst_to_err", 32'(te_le), 32'h0);
    chk("rst_byte_cnt", 32'(cnt_le), 32'h0);
    do_reset();
    chk("rst_byte_rdy", 32'(rdy_le), 32'h1);

    // ---- basic LE/BE packing, back-to-back bytes ----
    send(8'h11); send(8'h22); send(8'h33);
    chk("t1_cnt3", 32'(cnt_le), 32'd3);
    chk("t1_no_en_early", 32'(en_le), 32'h0);
    send(8'h44);
    chk("t1_word_en", 32'(en_le), 32'h1);
    chk("t1_word_le", wo_le, 32'h44332211);
    chk("t2_word_be", wo_be, 32'h11223344);
    chk("t1_cnt0", 32'(cnt_le), 32'd0);
    tick();
    chk("t1_en_one_cycle", 32'(en_le), 32'h0);
    chk("t1_word_stable", wo_le, 32'h44332211);

    // ---- hold defers delivery; 5th byte waits for byte_rdy ----
    do_reset();
    hold = 1'b1;               // hold in COLLECT must not matter
    send(8'h01); send(8'h02); send(8'h03);
    chk("t3_hold_collect_rdy", 32'(rdy_le), 32'h1);
    send(8'h04);               // completes with hold=1
    byte_vld = 1'b1; byte_in = 8'h55;
    chk("t3_pending_rdy", 32'(rdy_le), 32'h0);
    chk("t3_pending_no_en", 32'(en_le), 32'h0);
    chk("t3_pending_word", wo_le, 32'h04030201);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rdy_le || en_le || cnt_le != 3'd0) seen++;
    end
    chk("t3_pending_held", 32'(seen), 32'd0);
    hold = 1'b0;
    tick();
    chk("t3_word_en", 32'(en_le), 32'h1);
    chk("t3_rdy_back", 32'(rdy_le), 32'h1);
    chk("t3_5th_not_taken", 32'(cnt_le), 32'd0);
    tick();
    byte_vld = 1'b0;
    chk("t3_en_one_cycle", 32'(en_le), 32'h0);
    chk("t3_5th_taken", 32'(cnt_le), 32'd1);

    // ---- timeout discards a stale partial word ----
    do_reset();
    send(8'hAA); send(8'hBB);
    for (int i = 0; i < 9; i++) tick();
    chk("t4_no_to_yet", 32'(te_to), 32'h0);
    chk("t4_cnt_before_to", 32'(cnt_to), 32'd2);
    tick();
    chk("t4_to_err", 32'(te_to), 32'h1);
    chk("t4_cnt_cleared", 32'(cnt_to), 32'd0);
    tick();
    chk("t4_to_one_cycle", 32'(te_to), 32'h0);
    send(8'h01);
    for (int i = 0; i < 9; i++) tick();
    send(8'h02);               // lands on the edge the timeout would fire
    chk("t4_xfer_wins_to", 32'(te_to), 32'h0);
    chk("t4_xfer_wins_cnt", 32'(cnt_to), 32'd2);
    send(8'h03); send(8'h04);
    chk("t4_word_en", 32'(en_to), 32'h1);
    chk("t4_word", wo_to, 32'h04030201);

    // ---- streaming: 8 bytes with byte_vld stuck high ----
    do_reset();
    first_en = -1; second_en = -1; pulses = 0; seen = 0;
    for (int c = 0; c < 10; c++) begin
      byte_vld = (c < 8);
      byte_in  = 8'(c + 1);
      tick();
      if (!rdy_le) seen++;
      if (en_le) begin
        pulses++;
        if (first_en < 0) first_en = c; else second_en = c;
      end
    end
    byte_vld = 1'b0;
    chk("t5_rdy_never_drops", 32'(seen), 32'd0);
    chk("t5_pulses", 32'(pulses), 32'd2);
    chk("t5_first_en", 32'(first_en), 32'd3);
    chk("t5_second_en", 32'(second_en), 32'd7);
    chk("t5_word2", wo_le, 32'h08070605);

    // ---- asynchronous reset mid-word and in PENDING ----
    send(8'hC1); send(8'hC2);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_cnt", 32'(cnt_le), 32'd0);
    chk("t6_async_word", wo_le, 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (en_le || te_le || en_to || te_to) seen++;
    end
    chk("t6_quiet_after_rst", 32'(seen), 32'd0);
    send(8'hD1); send(8'hD2); send(8'hD3);
    hold = 1'b1;
    send(8'hD4);
    chk("t6_in_pending", 32'(rdy_le), 32'h0);
    #3 rst = 1'b1;
    #1;
    chk("t6_pend_rst_rdy", 32'(rdy_le), 32'h1);
    chk("t6_pend_rst_word", wo_le, 32'h0);
    rst = 1'b0;
    hold = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (en_le || te_le) seen++;
    end
    chk("t6_pend_lost", 32'(seen), 32'd0);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    chk("t6_fresh_en", 32'(en_le), 32'h1);
    chk("t6_fresh_word", wo_le, 32'hA4A3A2A1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Upstream feeder for the 32-bit enabled holding register.
- Accepts a stream of bytes from a byte-wide source (UART/SPI receiver) over a valid/ready handshake and packs BYTES bytes into one word.
- Presents the word with a single-cycle load strobe that drives the holding register's enable input directly.
- A downstream `hold` input defers delivery. A partial-word inactivity timeout discards stale bytes.

Parameters:
- BYTES, 4, bytes per word; word width is 8*BYTES (32 at default).
- LITTLE_ENDIAN, 1, 1 = first byte received lands in word_out[7:0]; 0 = first byte lands in word_out[8*BYTES-1 -: 8].
- TIMEOUT_CYC, 0, idle cycles allowed between bytes of a partial word; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; TIMEOUT_CYC must be < 2^TO_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- byte_in  in  8  data byte
- byte_vld  in  1  byte_in valid
- byte_rdy  out  1  packer can accept a byte this cycle
- hold  in  1  downstream busy; word delivery deferred while high
- word_out  out  8*BYTES  assembled word, registered
- word_en  out  1  one-cycle load strobe; connects to the holding register's en
- to_err  out  1  one-cycle pulse: partial word discarded on timeout
- byte_cnt  out  $clog2(BYTES+1)  bytes currently held in the partial word (debug/status)

Behaviour:
Reset (async assert, sync release):
- state=COLLECT; byte_cnt=0; word_out=0; word_en=0; to_err=0; timeout counter=0.
- byte_rdy=1 after reset release.

Transfer rule:
- A byte transfers on a rising edge where byte_vld && byte_rdy.
- byte_rdy is combinational: 1 in COLLECT, 0 in PENDING.

COLLECT:
- Each transfer writes byte_in into the lane selected by byte_cnt and LITTLE_ENDIAN, then increments byte_cnt.
- The final byte (byte_cnt==BYTES-1) clears byte_cnt to 0 and completes the word.
- Completion with hold==0 on that edge: word_en=1 in the following cycle (latency 1 from the last byte edge). State stays COLLECT, so back-to-back words are possible at full byte rate.
- Completion with hold==1: go to PENDING, word_en=0.

PENDING:
- byte_rdy=0 and word_out stays frozen.
- On the first edge sampling hold==0: word_en=1 for exactly the next cycle, then return to COLLECT.

word_en and word_out:
- word_en is never high for two consecutive cycles for the same word.
- word_out changes only on completion edges. The value presented with word_en is the complete new word; lanes are never partially updated while a word is visible.
- Lanes of the next partial word are assembled in a separate shadow register. word_out is the output register, loaded on completion.

Timeout (TIMEOUT_CYC>0):
- The counter runs in COLLECT while byte_cnt!=0 and no transfer occurs; any transfer clears it.
- When it reaches TIMEOUT_CYC: byte_cnt=0, shadow discarded, to_err=1 for one cycle, counter=0.
- If a byte transfers on the same edge the timeout would fire, the transfer wins and no timeout occurs.
- With byte_cnt==0 the counter is held at 0.
- The timeout counter is inactive in PENDING.

Boundary conditions:
- byte_vld while byte_rdy=0: ignored; the source must hold the byte.
- hold toggling in COLLECT has no effect.
- rst mid-word or in PENDING: the partial or pending word is lost, with no word_en and no to_err.
- BYTES=1: every accepted byte is a completion.

Decomposition:
- Shared package: state encoding (COLLECT, PENDING), the byte width constant (8), and a lane-index helper for endianness.
- One natural sub-module: packer_timeout, holding the idle counter with clear/enable inputs and a fire output, reusable by other receive paths.
- The holding register remains external.

Test Plan:
1. Reset, LE, hold=0; send 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> word_en high exactly one cycle after the 0x44 edge; word_out=0x44332211; byte_cnt back to 0.
2. LITTLE_ENDIAN=0, same bytes -> word_out=0x11223344.
3. hold=1 during the 4th byte and for 5 more cycles -> byte_rdy=0 for those cycles; word_en only after hold falls, one cycle wide; a 5th byte presented meanwhile is not accepted until byte_rdy=1.
4. TIMEOUT_CYC=10; send 0xAA, 0xBB, idle 10 cycles -> to_err pulse, byte_cnt=0; then 0x01, 0x02, 0x03, 0x04 -> word_out=0x04030201 with no trace of 0xAA/0xBB.
5. 8 bytes streamed with byte_vld stuck high, hold=0 -> two word_en pulses exactly 4 cycles apart; byte_rdy never drops.
6. Assert rst asynchronously after 2 bytes and again while in PENDING -> outputs return to reset values immediately; no word_en or to_err afterwards until 4 fresh bytes arrive.
